// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA raster timing generator with pixel clock enable,
//            programmable sync polarity and x/y-to-sync pipeline compensation.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIPE_DELAY = 1,
    parameter int CNT_W      = 11
) (
    input  logic             VGA_clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] xPixel,
    output logic [CNT_W-1:0] yPixel,
    output logic             req_active,
    output logic             display_area,
    output logic             blank_n,
    output logic             VGA_hSync,
    output logic             VGA_vSync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_H_LAST     = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST     = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             w_x_wrap;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_de_raw;
    logic             w_hs_d;
    logic             w_vs_d;
    logic             w_de_d;

    assign w_x_wrap = (r_x == c_H_LAST);

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (pix_en) begin
            if (w_x_wrap) begin
                r_x <= '0;
                if (r_y == c_V_LAST) begin
                    r_y <= '0;
                end else begin
                    r_y <= r_y + c_ONE;
                end
            end else begin
                r_x <= r_x + c_ONE;
            end
        end
    end

    // Vertical sync decodes the line counter only, so its edges fall at x == 0.
    assign w_hs_raw = (r_x >= c_HS_START) && (r_x < c_HS_END);
    assign w_vs_raw = (r_y >= c_VS_START) && (r_y < c_VS_END);
    assign w_de_raw = (r_x < c_H_ACT) && (r_y < c_V_ACT);

    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign w_hs_d = w_hs_raw;
            assign w_vs_d = w_vs_raw;
            assign w_de_d = w_de_raw;
        end else begin : g_pipe
            logic [PIPE_DELAY-1:0] r_hs_sr;
            logic [PIPE_DELAY-1:0] r_vs_sr;
            logic [PIPE_DELAY-1:0] r_de_sr;

            // Stages only shift on pixel-enabled cycles so the delay is counted in pixels.
            always_ff @(posedge VGA_clk) begin
                if (reset) begin
                    r_hs_sr <= '0;
                    r_vs_sr <= '0;
                    r_de_sr <= '0;
                end else if (pix_en) begin
                    r_hs_sr[0] <= w_hs_raw;
                    r_vs_sr[0] <= w_vs_raw;
                    r_de_sr[0] <= w_de_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_hs_sr[i] <= r_hs_sr[i-1];
                        r_vs_sr[i] <= r_vs_sr[i-1];
                        r_de_sr[i] <= r_de_sr[i-1];
                    end
                end
            end

            assign w_hs_d = r_hs_sr[PIPE_DELAY-1];
            assign w_vs_d = r_vs_sr[PIPE_DELAY-1];
            assign w_de_d = r_de_sr[PIPE_DELAY-1];
        end
    endgenerate

    assign xPixel       = r_x;
    assign yPixel       = r_y;
    assign req_active   = w_de_raw;
    assign display_area = w_de_d;
    assign blank_n      = w_de_d;
    assign VGA_hSync    = H_SYNC_POL ? w_hs_d : ~w_hs_d;
    assign VGA_vSync    = V_SYNC_POL ? w_vs_d : ~w_vs_d;
    assign line_start   = pix_en && !reset && (r_x == '0);
    assign frame_start  = line_start && (r_y == '0);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Randomised scoreboard bench for vga_timing_gen; two instances
//            (default line timing, and a short-line PIPE_DELAY=3 variant).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    // Instance A: default horizontal timing, shortened frame.
    localparam int c_A_HA = 640, c_A_HFP = 16, c_A_HS = 96, c_A_HBP = 48;
    localparam int c_A_VA = 6,   c_A_VFP = 2,  c_A_VS = 2,  c_A_VBP = 3;
    localparam int c_A_PD = 1;
    // Instance B: tiny lines, default vertical timing, active-high hSync.
    localparam int c_B_HA = 8,   c_B_HFP = 2,  c_B_HS = 2,  c_B_HBP = 2;
    localparam int c_B_VA = 480, c_B_VFP = 10, c_B_VS = 2,  c_B_VBP = 33;
    localparam int c_B_PD = 3;

    localparam int c_A_HT = c_A_HA + c_A_HFP + c_A_HS + c_A_HBP;
    localparam int c_A_VT = c_A_VA + c_A_VFP + c_A_VS + c_A_VBP;
    localparam int c_B_HT = c_B_HA + c_B_HFP + c_B_HS + c_B_HBP;
    localparam int c_B_VT = c_B_VA + c_B_VFP + c_B_VS + c_B_VBP;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        req;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } exp_t;

    logic        VGA_clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [10:0] a_x, a_y, b_x, b_y;
    logic        a_req, a_de, a_bn, a_hs, a_vs, a_ls, a_fs;
    logic        b_req, b_de, b_bn, b_hs, b_vs, b_ls, b_fs;

    exp_t qa[$];
    exp_t qb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   pos_a = 0, steps_a = 0, pos_b = 0, steps_b = 0;

    always #5 VGA_clk = ~VGA_clk;

    vga_timing_gen #(
        .H_ACTIVE(c_A_HA), .H_FP(c_A_HFP), .H_SYNC(c_A_HS), .H_BP(c_A_HBP),
        .V_ACTIVE(c_A_VA), .V_FP(c_A_VFP), .V_SYNC(c_A_VS), .V_BP(c_A_VBP),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE_DELAY(c_A_PD), .CNT_W(11)
    ) dut_a (
        .VGA_clk(VGA_clk), .reset(reset), .pix_en(pix_en),
        .xPixel(a_x), .yPixel(a_y), .req_active(a_req),
        .display_area(a_de), .blank_n(a_bn),
        .VGA_hSync(a_hs), .VGA_vSync(a_vs),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(c_B_HA), .H_FP(c_B_HFP), .H_SYNC(c_B_HS), .H_BP(c_B_HBP),
        .V_ACTIVE(c_B_VA), .V_FP(c_B_VFP), .V_SYNC(c_B_VS), .V_BP(c_B_VBP),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .PIPE_DELAY(c_B_PD), .CNT_W(11)
    ) dut_b (
        .VGA_clk(VGA_clk), .reset(reset), .pix_en(pix_en),
        .xPixel(b_x), .yPixel(b_y), .req_active(b_req),
        .display_area(b_de), .blank_n(b_bn),
        .VGA_hSync(b_hs), .VGA_vSync(b_vs),
        .line_start(b_ls), .frame_start(b_fs)
    );

    // Expected outputs for raster index pos; delayed outputs describe the
    // raster position pd pixel-steps earlier, or idle if not that many steps since reset.
    function automatic exp_t model(int pos, int steps, bit pe, bit rst,
                                   int ha, int hfp, int hsw, int hbp,
                                   int va, int vfp, int vsw, int vbp,
                                   int pd, bit hpol, bit vpol);
        exp_t e;
        int   ht, vt, x, y, p;
        bit   h, v, d;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        x = pos % ht;
        y = pos / ht;
        e.x   = 11'(x);
        e.y   = 11'(y);
        e.req = (x < ha) && (y < va);
        e.ls  = pe && !rst && (x == 0);
        e.fs  = e.ls && (y == 0);
        h = 1'b0; v = 1'b0; d = 1'b0;
        if (steps >= pd) begin
            p = (pos - pd + ht * vt) % (ht * vt);
            x = p % ht;
            y = p / ht;
            h = (x >= ha + hfp) && (x < ha + hfp + hsw);
            v = (y >= va + vfp) && (y < va + vfp + vsw);
            d = (x < ha) && (y < va);
        end
        e.de = d;
        e.hs = hpol ? h : !h;
        e.vs = vpol ? v : !v;
        return e;
    endfunction

    task automatic step(input bit r, input bit p);
        reset  = r;
        pix_en = p;
        qa.push_back(model(pos_a, steps_a, p, r, c_A_HA, c_A_HFP, c_A_HS, c_A_HBP,
                           c_A_VA, c_A_VFP, c_A_VS, c_A_VBP, c_A_PD, 1'b0, 1'b0));
        qb.push_back(model(pos_b, steps_b, p, r, c_B_HA, c_B_HFP, c_B_HS, c_B_HBP,
                           c_B_VA, c_B_VFP, c_B_VS, c_B_VBP, c_B_PD, 1'b1, 1'b0));
        @(posedge VGA_clk);
        #2;
        if (r) begin
            pos_a = 0; steps_a = 0; pos_b = 0; steps_b = 0;
        end else if (p) begin
            pos_a = (pos_a + 1) % (c_A_HT * c_A_VT);
            pos_b = (pos_b + 1) % (c_B_HT * c_B_VT);
            if (steps_a < 100) steps_a++;
            if (steps_b < 100) steps_b++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Monitor: every cycle the DUTs present outputs; compare against the queued model.
    initial begin
        exp_t e;
        forever begin
            @(negedge VGA_clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a.xPixel", 32'(a_x), 32'(e.x));
                chk("a.yPixel", 32'(a_y), 32'(e.y));
                chk("a.req_active", 32'(a_req), 32'(e.req));
                chk("a.display_area", 32'(a_de), 32'(e.de));
                chk("a.blank_n", 32'(a_bn), 32'(e.de));
                chk("a.hSync", 32'(a_hs), 32'(e.hs));
                chk("a.vSync", 32'(a_vs), 32'(e.vs));
                chk("a.line_start", 32'(a_ls), 32'(e.ls));
                chk("a.frame_start", 32'(a_fs), 32'(e.fs));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b.xPixel", 32'(b_x), 32'(e.x));
                chk("b.yPixel", 32'(b_y), 32'(e.y));
                chk("b.req_active", 32'(b_req), 32'(e.req));
                chk("b.display_area", 32'(b_de), 32'(e.de));
                chk("b.blank_n", 32'(b_bn), 32'(e.de));
                chk("b.hSync", 32'(b_hs), 32'(e.hs));
                chk("b.vSync", 32'(b_vs), 32'(e.vs));
                chk("b.line_start", 32'(b_ls), 32'(e.ls));
                chk("b.frame_start", 32'(b_fs), 32'(e.fs));
            end
        end
    end

    initial begin
        int guard;
        reset  = 1'b1;
        pix_en = 1'b0;
        @(posedge VGA_clk);
        #2;
        repeat (3) step(1'b1, 1'b0);
        // Free-running pixel clock: more than one full frame of A, vSync region of B.
        repeat (12000) step(1'b0, 1'b1);
        // Master-clock mode: enable every other cycle.
        for (int i = 0; i < 4000; i++) step(1'b0, (i % 2) == 0);
        // Reset asserted mid-line with pix_en high, then held-off restart.
        guard = 0;
        while (pos_a != 2 * c_A_HT + 300 && guard < 20000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        compared++;
        if (guard >= 20000) begin
            mismatched++;
            $display("FAIL reach_x300: got guard %0d expected < 20000", guard);
        end
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        repeat (50) step(1'b0, 1'b1);
        // Random enables with sparse random resets.
        for (int i = 0; i < 20000; i++)
            step(($urandom_range(0, 2999) == 0), ($urandom_range(0, 3) != 0));
        repeat (3) @(negedge VGA_clk);
        compared++;
        if (qa.size() != 0 || qb.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drain: got %0d/%0d entries expected 0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
